// File: rtl/dcc_packet_scheduler_if.sv
// -----------------------------------------------------------------------------
// dcc_packet_scheduler_if
// Command handshake between the host/CPU side and the DCC packet scheduler.
//
// Signals:
//   cmd_valid  host offers a command
//   cmd_addr   command address byte
//   cmd_data   command data byte
//   cmd_ready  scheduler buffer is empty and can take the command
//
// Modports:
//   master  command source (host side)
//   slave   scheduler side
// -----------------------------------------------------------------------------
interface dcc_packet_scheduler_if;
  logic       cmd_valid;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_addr,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_addr,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/dcc_packet_scheduler.sv
// -----------------------------------------------------------------------------
// dcc_packet_scheduler
// Feeds the DCC bit encoder one NMRA packet bit per encoder request. Each
// packet is: PREAMBLE_LEN ones, '0' addr, '0' data, '0' (addr^data), '1'.
// Every accepted command is transmitted REPEAT times. A one-deep buffer
// holds the next command while the current packet is on the wire.
//
// Build option DCC_IDLE_EN:
//   defined   -> gaps are filled with idle packets (addr 0xFF, data 0x00)
//   undefined -> gaps are a continuous run of '1's; a buffered command is
//                picked up once at least PREAMBLE_LEN ones have gone out
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   ack          encoder request; a rising edge asks for the next bit
//   next_bit     bit presented to the encoder
//   pkt_done     one-cycle pulse when a packet's end bit is emitted
//   sending_cmd  the packet in flight is a command, not idle
//   cmd          command handshake (slave side of dcc_packet_scheduler_if)
// -----------------------------------------------------------------------------
module dcc_packet_scheduler #(
  parameter int unsigned PREAMBLE_LEN = 14,
  parameter int unsigned REPEAT       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ack,
  output logic                  next_bit,
  output logic                  pkt_done,
  output logic                  sending_cmd,
  dcc_packet_scheduler_if.slave cmd
);

  typedef enum logic [1:0] {
    ST_PREAMBLE,
    ST_SEP,
    ST_BYTE,
    ST_END
  } state_e;

  localparam logic [4:0] PreLen   = 5'(PREAMBLE_LEN);
  localparam logic [4:0] PreLast  = 5'(PREAMBLE_LEN - 1);
  localparam logic [3:0] RepLast  = 4'(REPEAT - 1);
  localparam logic [7:0] IdleAddr = 8'hFF;
  localparam logic [7:0] IdleData = 8'h00;
`ifdef DCC_IDLE_EN
  localparam logic IdleEn = 1'b1;
`else
  localparam logic IdleEn = 1'b0;
`endif

  state_e     state_q, state_d;
  logic       ack_q;
  logic       step;
  logic [4:0] pre_cnt_q;
  logic [2:0] bit_idx_q;
  logic [1:0] byte_idx_q;
  logic [3:0] rep_cnt_q;
  logic       buf_full_q;
  logic [7:0] buf_addr_q, buf_data_q;
  logic [7:0] pkt_addr_q, pkt_data_q;
  logic       pkt_live_q;   // a packet is loaded; clear only while idling in '1's
  logic [7:0] cur_byte;
  logic       cur_bit;
  logic       pre_done;
  logic       pre_load;
  logic       take_buf;

  assign step          = ack & ~ack_q;
  assign cmd.cmd_ready = ~buf_full_q;

  // The buffer is taken either at the end bit (once repeats are exhausted)
  // or, with no packet loaded, straight out of the long run of '1's.
  assign take_buf = step &
                    (((state_q == ST_END) && (rep_cnt_q == 4'd0) && buf_full_q) ||
                     pre_load);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cur_bit  = 1'b1;
    pre_done = 1'b0;
    pre_load = 1'b0;

    case (byte_idx_q)
      2'd0:    cur_byte = pkt_addr_q;
      2'd1:    cur_byte = pkt_data_q;
      default: cur_byte = pkt_addr_q ^ pkt_data_q;
    endcase

    unique case (state_q)
      ST_PREAMBLE: begin
        cur_bit = 1'b1;
        if (pkt_live_q) pre_done = (pre_cnt_q == PreLast);
        else            pre_load = (pre_cnt_q >= PreLen) && buf_full_q;
        if (step && (pre_done || pre_load)) state_d = ST_SEP;
      end
      ST_SEP: begin
        cur_bit = 1'b0;
        if (step) state_d = ST_BYTE;
      end
      ST_BYTE: begin
        cur_bit = cur_byte[3'd7 - bit_idx_q];
        if (step && (bit_idx_q == 3'd7))
          state_d = (byte_idx_q == 2'd2) ? ST_END : ST_SEP;
      end
      ST_END: begin
        cur_bit = 1'b1;
        if (step) state_d = ST_PREAMBLE;
      end
      default: state_d = ST_PREAMBLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_PREAMBLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q       <= 1'b0;
      next_bit    <= 1'b1;
      pkt_done    <= 1'b0;
      sending_cmd <= 1'b0;
      pre_cnt_q   <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      rep_cnt_q   <= '0;
      buf_full_q  <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      pkt_addr_q  <= IdleAddr;
      pkt_data_q  <= IdleData;
      pkt_live_q  <= IdleEn;
    end else begin
      ack_q    <= ack;
      pkt_done <= 1'b0;

      // Write only into an empty buffer; a take only happens from a full one,
      // so a same-cycle write and take can never collide.
      if (cmd.cmd_valid && !buf_full_q) begin
        buf_full_q <= 1'b1;
        buf_addr_q <= cmd.cmd_addr;
        buf_data_q <= cmd.cmd_data;
      end

      if (step) begin
        next_bit <= cur_bit;

        unique case (state_q)
          ST_PREAMBLE: begin
            if (pre_done || pre_load)   pre_cnt_q <= '0;
            else if (pre_cnt_q != PreLen) pre_cnt_q <= pre_cnt_q + 5'd1;
          end
          ST_BYTE: begin
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7)
              byte_idx_q <= (byte_idx_q == 2'd2) ? 2'd0 : byte_idx_q + 2'd1;
          end
          ST_END:  pkt_done <= 1'b1;
          default: ;
        endcase

        if (take_buf) begin
          pkt_addr_q  <= buf_addr_q;
          pkt_data_q  <= buf_data_q;
          rep_cnt_q   <= RepLast;
          sending_cmd <= 1'b1;
          pkt_live_q  <= 1'b1;
          buf_full_q  <= 1'b0;
        end else if (state_q == ST_END) begin
          if (rep_cnt_q != 4'd0) begin
            rep_cnt_q <= rep_cnt_q - 4'd1;
          end else begin
            pkt_addr_q  <= IdleAddr;
            pkt_data_q  <= IdleData;
            sending_cmd <= 1'b0;
            pkt_live_q  <= IdleEn;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dcc_packet_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dcc_packet_scheduler
// Random encoder requests and host commands drive the scheduler. A reference
// model holds the current packet as a plain queue of bits and decides the next
// packet from a repeat count and a one-entry command buffer. Each cycle the
// driver pushes the expected outputs into a queue; an independent monitor
// pops and compares them one time unit after every rising clock edge.
// Follows the DCC_IDLE_EN build option of the design.
// -----------------------------------------------------------------------------
module tb_dcc_packet_scheduler;
  localparam int PL       = 14;
  localparam int REP      = 3;
  localparam int PKT_BITS = PL + 28;
  localparam int PHASE_CYCLES = 3000;

  logic clk = 1'b0;
  logic reset;
  logic ack;
  logic next_bit;
  logic pkt_done;
  logic sending_cmd;

  dcc_packet_scheduler_if cmd_if ();

  dcc_packet_scheduler #(
    .PREAMBLE_LEN(PL),
    .REPEAT      (REP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ack        (ack),
    .next_bit   (next_bit),
    .pkt_done   (pkt_done),
    .sending_cmd(sending_cmd),
    .cmd        (cmd_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic nb;
    logic rdy;
    logic done;
    logic snd;
  } exp_t;

  exp_t       exp_q[$];
  bit         m_pkt[$];      // remaining bits of the packet on the wire
  bit         m_waiting;     // no packet loaded, emitting filler '1's
  int         m_ones;
  int         m_rep;
  bit         m_buf_full;
  logic [7:0] m_buf_addr, m_buf_data;
  logic [7:0] m_cur_addr, m_cur_data;
  bit         m_sending, m_bit, m_done, m_ack_q;

  function automatic void build_pkt(input logic [7:0] a, input logic [7:0] d,
                                    input bit with_pre);
    logic [7:0] bytes [3];
    bytes[0] = a;
    bytes[1] = d;
    bytes[2] = a ^ d;
    m_pkt.delete();
    if (with_pre) for (int i = 0; i < PL; i++) m_pkt.push_back(1'b1);
    for (int b = 0; b < 3; b++) begin
      m_pkt.push_back(1'b0);
      for (int i = 7; i >= 0; i--) m_pkt.push_back(bytes[b][i]);
    end
    m_pkt.push_back(1'b1);
  endfunction

  function automatic void take_cmd(input bit with_pre);
    m_cur_addr = m_buf_addr;
    m_cur_data = m_buf_data;
    m_rep      = REP - 1;
    m_sending  = 1'b1;
    m_buf_full = 1'b0;
    m_waiting  = 1'b0;
    build_pkt(m_cur_addr, m_cur_data, with_pre);
  endfunction

  function automatic void go_idle();
    m_sending  = 1'b0;
    m_cur_addr = 8'hFF;
    m_cur_data = 8'h00;
`ifdef DCC_IDLE_EN
    m_waiting = 1'b0;
    build_pkt(8'hFF, 8'h00, 1'b1);
`else
    m_waiting = 1'b1;
    m_ones    = 0;
    m_pkt.delete();
`endif
  endfunction

  function automatic void next_packet();
    if (m_rep > 0) begin
      m_rep--;
      build_pkt(m_cur_addr, m_cur_data, 1'b1);
    end else if (m_buf_full) begin
      take_cmd(1'b1);
    end else begin
      go_idle();
    end
  endfunction

  function automatic void model_reset();
    m_ack_q    = 1'b0;
    m_bit      = 1'b1;
    m_done     = 1'b0;
    m_rep      = 0;
    m_buf_full = 1'b0;
    m_ones     = 0;
    go_idle();
  endfunction

  // Effect of the next rising edge given the inputs driven for it.
  function automatic void model_cycle(input bit rst, input bit a, input bit v,
                                      input logic [7:0] addr, input logic [7:0] data);
    bit stp;
    bit accept;
    if (rst) begin
      model_reset();
    end else begin
      stp     = a && !m_ack_q;
      m_ack_q = a;
      m_done  = 1'b0;
      accept  = v && !m_buf_full;
      if (stp) begin
        if (m_waiting) begin
          m_bit = 1'b1;
          if (m_ones >= PL && m_buf_full) take_cmd(1'b0);
          else if (m_ones < PL)           m_ones++;
        end else begin
          m_bit = m_pkt.pop_front();
          if (m_pkt.size() == 0) begin
            m_done = 1'b1;
            next_packet();
          end
        end
      end
      if (accept) begin
        m_buf_full = 1'b1;
        m_buf_addr = addr;
        m_buf_data = data;
      end
    end
    exp_q.push_back('{nb: m_bit, rdy: !m_buf_full, done: m_done, snd: m_sending});
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("next_bit",    next_bit,         e.nb);
        check("cmd_ready",   cmd_if.cmd_ready, e.rdy);
        check("pkt_done",    pkt_done,         e.done);
        check("sending_cmd", sending_cmd,      e.snd);
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    bit         r, a, v, stp_next, did_reset;
    int         rst_hold;
    logic [7:0] addr, data;

    reset            = 1'b1;
    ack              = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_addr  = 8'h00;
    cmd_if.cmd_data  = 8'h00;
    model_reset();
    #1;
    check("rst_next_bit",    next_bit,         1'b1);
    check("rst_cmd_ready",   cmd_if.cmd_ready, 1'b1);
    check("rst_pkt_done",    pkt_done,         1'b0);
    check("rst_sending_cmd", sending_cmd,      1'b0);

    rst_hold = 3;
    a        = 1'b0;
    for (int phase = 0; phase < 4; phase++) begin
      did_reset = 1'b0;
      for (int cyc = 0; cyc < PHASE_CYCLES; cyc++) begin
        @(negedge clk);

        // Reset: initial hold, then once mid-command in odd phases.
        r = 1'b0;
        if (rst_hold > 0) begin
          r = 1'b1;
          rst_hold--;
        end else if (phase[0] && !did_reset && m_sending && !m_waiting &&
                     m_pkt.size() == PKT_BITS - 20) begin
          r         = 1'b1;
          rst_hold  = 2;
          did_reset = 1'b1;
        end

        if ($urandom_range(0, 3) != 0) a = !a;
        stp_next = a && !m_ack_q;
        addr     = 8'($urandom);
        data     = 8'($urandom);
        case (phase)
          0:       v = 1'b0;
          1:       v = ($urandom_range(0, 149) == 0);
          2:       v = 1'b1;
          default: v = (stp_next && !m_waiting && m_pkt.size() == 1 && !m_buf_full) ||
                       ($urandom_range(0, 299) == 0);
        endcase

        ack              = a;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_addr  = addr;
        cmd_if.cmd_data  = data;
        if (r && !reset) begin
          reset = 1'b1;
          #1;
          check("async_next_bit",  next_bit,         1'b1);
          check("async_cmd_ready", cmd_if.cmd_ready, 1'b1);
          check("async_pkt_done",  pkt_done,         1'b0);
          check("async_sending",   sending_cmd,      1'b0);
        end
        reset = r;
        model_cycle(r, a, v, addr, data);
      end
    end

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
